// File: rtl/raizing_colmix_pkg.sv
// raizing_colmix_pkg
//   Shared defaults and helpers for the pipelined layer colour mixer.
//   DEF_*        : default parameter values for layer count and field widths
//   DEF_SLICE_W  : width of one packed {prio,index} layer pixel
//   MAX_PIX_W    : widest palette index the helper function accepts
//   is_opaque()  : a pixel is visible when its index is non-zero and its layer is enabled
package raizing_colmix_pkg;

  localparam int unsigned DEF_NUM_LAYERS = 4;
  localparam int unsigned DEF_PRIO_W     = 4;
  localparam int unsigned DEF_PIX_W      = 11;
  localparam int unsigned DEF_SLICE_W    = DEF_PRIO_W + DEF_PIX_W;
  localparam int unsigned MAX_PIX_W      = 16;

  function automatic logic is_opaque(input logic [MAX_PIX_W-1:0] idx, input logic en);
    return en && (idx != '0);
  endfunction

endpackage

// File: rtl/raizing_colmix_sel.sv
// raizing_colmix_sel
//   Combinational NUM_LAYERS-way priority selector.
//   opaque_i : per-layer opaque flag
//   prio_i   : per-layer priority, layer k at [k*PRIO_W +: PRIO_W], unsigned compare
//   idx_i    : per-layer palette index, layer k at [k*PIX_W +: PIX_W]
//   found_o  : at least one layer is opaque
//   idx_o    : index of the winning layer (0 when none)
module raizing_colmix_sel #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned PRIO_W     = 4,
  parameter int unsigned PIX_W      = 11
) (
  input  logic [NUM_LAYERS-1:0]        opaque_i,
  input  logic [NUM_LAYERS*PRIO_W-1:0] prio_i,
  input  logic [NUM_LAYERS*PIX_W-1:0]  idx_i,
  output logic                         found_o,
  output logic [PIX_W-1:0]             idx_o
);

  logic              found;
  logic [PRIO_W-1:0] best;

  // Scanning upward with >= lets a later (higher-numbered) layer take an equal-priority tie.
  always_comb begin
    found = 1'b0;
    best  = '0;
    idx_o = '0;
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      if (opaque_i[k] && (!found || prio_i[k*PRIO_W +: PRIO_W] >= best)) begin
        found = 1'b1;
        best  = prio_i[k*PRIO_W +: PRIO_W];
        idx_o = idx_i[k*PIX_W +: PIX_W];
      end
    end
    found_o = found;
  end

endmodule

// File: rtl/raizing_colmix_pipe.sv
// raizing_colmix_pipe
//   Two-stage pipelined colour mixer: NUM_LAYERS prioritised layers plus an overlay text layer.
//   Stage 1 registers opaque flags / prio / index / text / ACTIVE; stage 2 picks the visible index.
//   Layer and text enables come from an active mask loaded from a pending shadow mask on the
//   VBLANK rising edge, so the visible layer set only changes between frames.
//   Optional feature macro: COLMIX_BACKDROP_EN -- shadowed backdrop index replaces 0 for blank
//   and inactive dots; without it BG_WE/BG_DATA are ignored.
//   Ports:
//     CLK96, RESET96 (sync, active high), PIXEL_CEN (pipeline advance), ACTIVE, VBLANK,
//     TEXT_PIXEL, LAYER_PIXEL ({prio,index} per layer), MASK_WE/MASK_DATA, BG_WE/BG_DATA,
//     FINAL_PIXEL, FINAL_VALID.
module raizing_colmix_pipe
  import raizing_colmix_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int unsigned PRIO_W     = DEF_PRIO_W,
  parameter int unsigned PIX_W      = DEF_PIX_W
) (
  input  logic                                  CLK96,
  input  logic                                  RESET96,
  input  logic                                  PIXEL_CEN,
  input  logic                                  ACTIVE,
  input  logic                                  VBLANK,
  input  logic [PIX_W-1:0]                      TEXT_PIXEL,
  input  logic [NUM_LAYERS*(PRIO_W+PIX_W)-1:0]  LAYER_PIXEL,
  input  logic                                  MASK_WE,
  input  logic [NUM_LAYERS:0]                   MASK_DATA,
  input  logic                                  BG_WE,
  input  logic [PIX_W-1:0]                      BG_DATA,
  output logic [PIX_W-1:0]                      FINAL_PIXEL,
  output logic                                  FINAL_VALID
);

  localparam int unsigned SLICE_W = PRIO_W + PIX_W;

  logic [NUM_LAYERS-1:0]        opq_d,  s1_opq_q;
  logic [NUM_LAYERS*PRIO_W-1:0] prio_d, s1_prio_q;
  logic [NUM_LAYERS*PIX_W-1:0]  idx_d,  s1_idx_q;
  logic [PIX_W-1:0]             s1_txt_q;
  logic                         txt_opq_d, s1_txt_opq_q;
  logic                         s1_act_q;
  logic                         vblank_q;
  logic                         vb_rise;
  logic [NUM_LAYERS:0]          pend_mask_q, act_mask_q;
  logic                         sel_found;
  logic [PIX_W-1:0]             sel_idx;
  logic [PIX_W-1:0]             blank;
  logic [PIX_W-1:0]             pix_d;
  logic                         valid_d;

  assign vb_rise = VBLANK & ~vblank_q;

  always_comb begin
    opq_d  = '0;
    prio_d = '0;
    idx_d  = '0;
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      idx_d[k*PIX_W +: PIX_W]   = LAYER_PIXEL[k*SLICE_W +: PIX_W];
      prio_d[k*PRIO_W +: PRIO_W] = LAYER_PIXEL[k*SLICE_W+PIX_W +: PRIO_W];
      opq_d[k] = is_opaque(MAX_PIX_W'(LAYER_PIXEL[k*SLICE_W +: PIX_W]), act_mask_q[k]);
    end
    txt_opq_d = is_opaque(MAX_PIX_W'(TEXT_PIXEL), act_mask_q[NUM_LAYERS]);
  end

  raizing_colmix_sel #(
    .NUM_LAYERS (NUM_LAYERS),
    .PRIO_W     (PRIO_W),
    .PIX_W      (PIX_W)
  ) u_sel (
    .opaque_i (s1_opq_q),
    .prio_i   (s1_prio_q),
    .idx_i    (s1_idx_q),
    .found_o  (sel_found),
    .idx_o    (sel_idx)
  );

`ifdef COLMIX_BACKDROP_EN
  logic [PIX_W-1:0] bg_pend_q, bg_q;

  // Backdrop shares the mask's shadow scheme, including same-cycle write-through on commit.
  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      bg_pend_q <= '0;
      bg_q      <= '0;
    end else begin
      if (BG_WE) bg_pend_q <= BG_DATA;
      if (vb_rise) bg_q <= BG_WE ? BG_DATA : bg_pend_q;
    end
  end

  assign blank = bg_q;
`else
  logic unused_bg;
  assign unused_bg = ^{BG_WE, BG_DATA};
  assign blank     = '0;
`endif

  // Text overrides every layer; inactive dots always show blank.
  always_comb begin
    valid_d = s1_act_q;
    pix_d   = blank;
    if (s1_act_q) begin
      if (s1_txt_opq_q)   pix_d = s1_txt_q;
      else if (sel_found) pix_d = sel_idx;
    end
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      s1_opq_q     <= '0;
      s1_prio_q    <= '0;
      s1_idx_q     <= '0;
      s1_txt_q     <= '0;
      s1_txt_opq_q <= 1'b0;
      s1_act_q     <= 1'b0;
      FINAL_PIXEL  <= '0;
      FINAL_VALID  <= 1'b0;
      vblank_q     <= 1'b0;
      pend_mask_q  <= '1;
      act_mask_q   <= '1;
    end else begin
      if (PIXEL_CEN) begin
        s1_opq_q     <= opq_d;
        s1_prio_q    <= prio_d;
        s1_idx_q     <= idx_d;
        s1_txt_q     <= TEXT_PIXEL;
        s1_txt_opq_q <= txt_opq_d;
        s1_act_q     <= ACTIVE;
        FINAL_PIXEL  <= pix_d;
        FINAL_VALID  <= valid_d;
      end
      vblank_q <= VBLANK;
      if (MASK_WE) pend_mask_q <= MASK_DATA;
      // A write landing on the commit edge goes straight to the active mask.
      if (vb_rise) act_mask_q <= MASK_WE ? MASK_DATA : pend_mask_q;
    end
  end

endmodule

// File: tb/tb_raizing_colmix_pipe.sv
module tb_raizing_colmix_pipe;

  localparam int N  = 4;
  localparam int PR = 4;
  localparam int PW = 11;
  localparam int SW = PR + PW;

  logic            CLK96 = 1'b0;
  logic            RESET96 = 1'b1;
  logic            PIXEL_CEN = 1'b0;
  logic            ACTIVE = 1'b0;
  logic            VBLANK = 1'b0;
  logic [PW-1:0]   TEXT_PIXEL = '0;
  logic [N*SW-1:0] LAYER_PIXEL = '0;
  logic            MASK_WE = 1'b0;
  logic [N:0]      MASK_DATA = '1;
  logic            BG_WE = 1'b0;
  logic [PW-1:0]   BG_DATA = '0;
  logic [PW-1:0]   FINAL_PIXEL;
  logic            FINAL_VALID;

  int checks = 0;
  int errors = 0;

  raizing_colmix_pipe #(
    .NUM_LAYERS (N),
    .PRIO_W     (PR),
    .PIX_W      (PW)
  ) dut (
    .CLK96       (CLK96),
    .RESET96     (RESET96),
    .PIXEL_CEN   (PIXEL_CEN),
    .ACTIVE      (ACTIVE),
    .VBLANK      (VBLANK),
    .TEXT_PIXEL  (TEXT_PIXEL),
    .LAYER_PIXEL (LAYER_PIXEL),
    .MASK_WE     (MASK_WE),
    .MASK_DATA   (MASK_DATA),
    .BG_WE       (BG_WE),
    .BG_DATA     (BG_DATA),
    .FINAL_PIXEL (FINAL_PIXEL),
    .FINAL_VALID (FINAL_VALID)
  );

  always #5 CLK96 = ~CLK96;

  // Reference model: the visible dot is resolved from the rules when a pixel enters,
  // then delayed by one more strobe; blank is taken at the output strobe.
  logic [N:0]    m_pend, m_act;
  logic          m_vbq;
  logic [PW-1:0] m_bg_pend, m_bg;
  logic          m_s1_act, m_s1_found;
  logic [PW-1:0] m_s1_pix;
  logic [PW-1:0] m_out_pix;
  logic          m_out_valid;

  always @(posedge CLK96) begin : model
    int            best;
    logic [N:0]    new_act;
    logic [PW-1:0] new_bg, blank, idx;
    logic [PR-1:0] pr;
    if (RESET96) begin
      m_pend = '1; m_act = '1; m_vbq = 0; m_bg_pend = '0; m_bg = '0;
      m_s1_act = 0; m_s1_found = 0; m_s1_pix = '0; m_out_pix = '0; m_out_valid = 0;
    end else begin
      if (PIXEL_CEN) begin
`ifdef COLMIX_BACKDROP_EN
        blank = m_bg;
`else
        blank = '0;
`endif
        m_out_valid = m_s1_act;
        m_out_pix   = (m_s1_act && m_s1_found) ? m_s1_pix : blank;
        m_s1_act    = ACTIVE;
        m_s1_found  = 0;
        m_s1_pix    = '0;
        if (TEXT_PIXEL != 0 && m_act[N]) begin
          m_s1_found = 1;
          m_s1_pix   = TEXT_PIXEL;
        end else begin
          best = -1;
          for (int k = 0; k < N; k++) begin
            idx = LAYER_PIXEL[k*SW +: PW];
            pr  = LAYER_PIXEL[k*SW+PW +: PR];
            if (idx != 0 && m_act[k] && int'(pr) > best) best = int'(pr);
          end
          for (int k = 0; k < N; k++) begin
            idx = LAYER_PIXEL[k*SW +: PW];
            pr  = LAYER_PIXEL[k*SW+PW +: PR];
            if (idx != 0 && m_act[k] && int'(pr) == best) m_s1_pix = idx;
          end
          m_s1_found = (best >= 0);
        end
      end
      new_act = m_act;
      new_bg  = m_bg;
      if (VBLANK && !m_vbq) begin
        new_act = MASK_WE ? MASK_DATA : m_pend;
        new_bg  = BG_WE ? BG_DATA : m_bg_pend;
      end
      if (MASK_WE) m_pend = MASK_DATA;
      if (BG_WE) m_bg_pend = BG_DATA;
      m_act = new_act;
      m_bg  = new_bg;
      m_vbq = VBLANK;
    end
  end

`ifdef COLMIX_BACKDROP_EN
  localparam logic [PW-1:0] BG_EXP = 11'h0AB;
`else
  localparam logic [PW-1:0] BG_EXP = 11'h000;
`endif

  task automatic cyc();
    @(posedge CLK96);
    @(negedge CLK96);
  endtask

  task automatic strobe();
    PIXEL_CEN = 1'b1;
    cyc();
    PIXEL_CEN = 1'b0;
    MASK_WE   = 1'b0;
    BG_WE     = 1'b0;
  endtask

  task automatic set_layer(input int k, input logic [PR-1:0] p, input logic [PW-1:0] i);
    LAYER_PIXEL[k*SW +: SW] = {p, i};
  endtask

  task automatic clear_in();
    LAYER_PIXEL = '0; TEXT_PIXEL = '0; ACTIVE = 1'b1; PIXEL_CEN = 1'b0;
    MASK_WE = 1'b0; BG_WE = 1'b0; VBLANK = 1'b0;
  endtask

  task automatic test_reset();
    clear_in();
    RESET96 = 1'b1;
    cyc(); cyc();
    RESET96 = 1'b0;
    checks++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset: got %h/%b expected 000/0", FINAL_PIXEL, FINAL_VALID);
    end
  endtask

  task automatic test_priority();
    logic [PW-1:0] exp_pix [3];
    clear_in();
    set_layer(0, 4'd2, 11'h010);
    set_layer(3, 4'd2, 11'h300);
    strobe();
    checks++;
    if (FINAL_VALID !== 1'b0) begin
      errors++;
      $display("FAIL prio_latency: got valid %b after one strobe expected 0", FINAL_VALID);
    end
    strobe();
    exp_pix[0] = 11'h300;
    checks++;
    if (FINAL_PIXEL !== exp_pix[0] || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL prio_tie: got %h/%b expected %h/1", FINAL_PIXEL, FINAL_VALID, exp_pix[0]);
    end
    clear_in();
    set_layer(1, 4'd9, 11'h111);
    set_layer(3, 4'd3, 11'h333);
    TEXT_PIXEL = 11'h7FF;
    strobe(); strobe();
    exp_pix[1] = 11'h7FF;
    checks++;
    if (FINAL_PIXEL !== exp_pix[1] || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL prio_text: got %h/%b expected %h/1", FINAL_PIXEL, FINAL_VALID, exp_pix[1]);
    end
    TEXT_PIXEL = '0;
    strobe(); strobe();
    exp_pix[2] = 11'h111;
    checks++;
    if (FINAL_PIXEL !== exp_pix[2] || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL prio_high: got %h/%b expected %h/1", FINAL_PIXEL, FINAL_VALID, exp_pix[2]);
    end
  endtask

  task automatic test_mask_shadow();
    clear_in();
    set_layer(3, 4'hF, 11'h333);
    MASK_DATA = 5'b1_0111;
    MASK_WE   = 1'b1;
    strobe(); strobe(); strobe();
    checks++;
    if (FINAL_PIXEL !== 11'h333 || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL mask_pending: got %h/%b expected 333/1", FINAL_PIXEL, FINAL_VALID);
    end
    VBLANK = 1'b1;
    cyc();
    strobe(); strobe();
    checks++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL mask_commit: got %h/%b expected 000/1", FINAL_PIXEL, FINAL_VALID);
    end
    MASK_DATA = '1;
    MASK_WE   = 1'b1;
    cyc();
    MASK_WE = 1'b0;
    strobe(); strobe();
    checks++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL mask_held_vblank: got %h/%b expected 000/1", FINAL_PIXEL, FINAL_VALID);
    end
    VBLANK = 1'b0; cyc();
    VBLANK = 1'b1; cyc();
    strobe(); strobe();
    checks++;
    if (FINAL_PIXEL !== 11'h333 || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL mask_recommit: got %h/%b expected 333/1", FINAL_PIXEL, FINAL_VALID);
    end
    VBLANK = 1'b0; cyc();
    TEXT_PIXEL = 11'h123;
    MASK_DATA  = 5'b0_1111;
    MASK_WE    = 1'b1;
    VBLANK     = 1'b1;
    cyc();
    MASK_WE = 1'b0;
    VBLANK  = 1'b0;
    strobe(); strobe();
    checks++;
    if (FINAL_PIXEL !== 11'h333 || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL mask_same_cycle: got %h/%b expected 333/1", FINAL_PIXEL, FINAL_VALID);
    end
    MASK_DATA = '1; MASK_WE = 1'b1; VBLANK = 1'b1;
    cyc();
    MASK_WE = 1'b0; VBLANK = 1'b0;
    strobe(); strobe();
    checks++;
    if (FINAL_PIXEL !== 11'h123 || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL mask_text_back: got %h/%b expected 123/1", FINAL_PIXEL, FINAL_VALID);
    end
  endtask

  task automatic test_blank_backdrop();
    clear_in();
    strobe(); strobe();
    checks++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL blank_zero: got %h/%b expected 000/1", FINAL_PIXEL, FINAL_VALID);
    end
    BG_DATA = 11'h0AB;
    BG_WE   = 1'b1;
    cyc();
    BG_WE = 1'b0;
    strobe(); strobe();
    checks++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL blank_bg_pending: got %h/%b expected 000/1", FINAL_PIXEL, FINAL_VALID);
    end
    VBLANK = 1'b1; cyc();
    VBLANK = 1'b0;
    strobe(); strobe();
    checks++;
    if (FINAL_PIXEL !== BG_EXP || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL blank_bg_commit: got %h/%b expected %h/1", FINAL_PIXEL, FINAL_VALID, BG_EXP);
    end
  endtask

  task automatic test_inactive_hold();
    clear_in();
    ACTIVE = 1'b0;
    set_layer(0, 4'd1, 11'h055);
    strobe(); strobe();
    checks++;
    if (FINAL_PIXEL !== BG_EXP || FINAL_VALID !== 1'b0) begin
      errors++;
      $display("FAIL inactive: got %h/%b expected %h/0", FINAL_PIXEL, FINAL_VALID, BG_EXP);
    end
    for (int c = 0; c < 10; c++) begin
      ACTIVE      = 1'b1;
      TEXT_PIXEL  = PW'($urandom);
      LAYER_PIXEL = {$urandom, $urandom};
      cyc();
      checks++;
      if (FINAL_PIXEL !== BG_EXP || FINAL_VALID !== 1'b0) begin
        errors++;
        $display("FAIL cen_hold[%0d]: got %h/%b expected %h/0", c, FINAL_PIXEL, FINAL_VALID, BG_EXP);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_in();
    MASK_DATA = 5'b0_1111; MASK_WE = 1'b1; VBLANK = 1'b1;
    cyc();
    MASK_WE = 1'b0; VBLANK = 1'b0;
    TEXT_PIXEL = 11'h456;
    set_layer(2, 4'd1, 11'h222);
    strobe(); strobe();
    checks++;
    if (FINAL_PIXEL !== 11'h222 || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got %h/%b expected 222/1", FINAL_PIXEL, FINAL_VALID);
    end
    strobe();
    RESET96 = 1'b1; cyc();
    RESET96 = 1'b0;
    checks++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got %h/%b expected 000/0", FINAL_PIXEL, FINAL_VALID);
    end
    strobe();
    checks++;
    if (FINAL_PIXEL !== 11'h000 || FINAL_VALID !== 1'b0) begin
      errors++;
      $display("FAIL rst_flush: got %h/%b expected 000/0", FINAL_PIXEL, FINAL_VALID);
    end
    strobe();
    checks++;
    if (FINAL_PIXEL !== 11'h456 || FINAL_VALID !== 1'b1) begin
      errors++;
      $display("FAIL rst_mask_ones: got %h/%b expected 456/1", FINAL_PIXEL, FINAL_VALID);
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] idx;
    clear_in();
    for (int c = 0; c < 600; c++) begin
      PIXEL_CEN = ($urandom_range(0, 1) == 1);
      ACTIVE    = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < N; k++) begin
        idx = ($urandom_range(0, 3) == 0) ? '0 : PW'($urandom);
        set_layer(k, PR'($urandom_range(0, 3)), idx);
      end
      TEXT_PIXEL = ($urandom_range(0, 3) == 0) ? PW'($urandom) : '0;
      MASK_WE    = ($urandom_range(0, 9) == 0);
      MASK_DATA  = (N+1)'($urandom);
      BG_WE      = ($urandom_range(0, 19) == 0);
      BG_DATA    = PW'($urandom);
      if ($urandom_range(0, 11) == 0) VBLANK = ~VBLANK;
      RESET96    = ($urandom_range(0, 199) == 0);
      cyc();
      checks++;
      if (FINAL_PIXEL !== m_out_pix || FINAL_VALID !== m_out_valid) begin
        errors++;
        $display("FAIL random[%0d]: got %h/%b expected %h/%b", c, FINAL_PIXEL, FINAL_VALID,
                 m_out_pix, m_out_valid);
      end
    end
    RESET96 = 1'b0;
  endtask

  initial begin
    @(negedge CLK96);
    test_reset();
    test_priority();
    test_mask_shadow();
    test_blank_backdrop();
    test_inactive_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
